ahb_uart_v2: RTL and testbench

Second-generation UART peripheral on the bus_protocol_if peripheral_vital port. Its predecessor had a fixed frame and a single holding register; this block adds:
- parametrised data width and FIFO depth
- a runtime baud divisor
- optional parity and two stop bits
- RTS/CTS flow control
- sticky error flags
It sits behind the AHB bus adapter as a memory-mapped slave and drives the external rx/tx/cts/rts pins.

---
 rtl/ahb_uart_v2_pkg.sv | 28 ++
 rtl/ahb_uart_v2_if.sv | 19 +
 rtl/ahb_uart_v2_fifo.sv | 53 +++++
 rtl/ahb_uart_v2.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ahb_uart_v2.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_uart_v2_pkg.sv
// uart_pkg: register offsets, CTRL/STATUS bit positions and the serial
// FSM state type shared by the transmitter and receiver of ahb_uart_v2.
package uart_pkg;
    localparam logic [4:0] ADDR_RXDATA = 5'h00;
    localparam logic [4:0] ADDR_TXDATA = 5'h04;
    localparam logic [4:0] ADDR_STATUS = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_BAUD   = 5'h10;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_PAR_EN    = 2;
    localparam int CTRL_PAR_ODD   = 3;
    localparam int CTRL_TWO_STOP  = 4;
    localparam int CTRL_FLOW_EN   = 5;
    localparam int CTRL_LOOPBACK  = 6;

    localparam int ST_RX_EMPTY    = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_OVERRUN     = 4;
    localparam int ST_FRAMING_ERR = 5;
    localparam int ST_PARITY_ERR  = 6;
    localparam int ST_TX_BUSY     = 7;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/ahb_uart_v2_if.sv
// bus_protocol_if: simple memory-mapped peripheral port seen from the
// AHB adapter (master) and from the peripheral (peripheral_vital / slave).
interface bus_protocol_if;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport master (output wen, ren, addr, wdata, strobe,
                    input  rdata, error, request_stall);
    modport peripheral_vital (input  wen, ren, addr, wdata, strobe,
                              output rdata, error, request_stall);
    modport slave (input  wen, ren, addr, wdata, strobe,
                   output rdata, error, request_stall);
endinterface

// File: rtl/ahb_uart_v2_fifo.sv
// uart_fifo: synchronous FIFO with wrap-bit pointers. A pop on a full FIFO
// frees the slot for a same-cycle push; a push+pop on empty only pushes.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer advance for accepted pushes and pops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO at once
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail slot
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/ahb_uart_v2.sv
// ahb_uart_v2: memory-mapped UART with TX/RX FIFOs, runtime baud divisor,
// optional parity, two stop bits, RTS/CTS and sticky error flags.
// Define UART_LOOPBACK_EN to enable CTRL[6] internal tx->rx loopback.
module ahb_uart_v2
    import uart_pkg::*;
#(
    parameter int                   DATA_BITS   = 8,
    parameter int                   FIFO_DEPTH  = 8,
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(868)
) (
    input  logic clk,
    input  logic nReset,
    input  logic rx,
    output logic tx,
    input  logic cts,
    output logic rts,
    bus_protocol_if.peripheral_vital bp
);
    localparam int                   CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
    localparam logic [3:0]           LAST_BIT = 4'(DATA_BITS - 1);

    logic [6:0]           ctrl_q, ctrl_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d;
    logic                 overrun_q, overrun_d, framing_q, framing_d, parity_q, parity_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q, cts_s1_q, cts_s2_q, rts_q, rts_d;
    uart_state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_q, tx_d, rx_perr_q, rx_perr_d;
    logic                 tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_rdata, rx_rdata;
    logic [CW-1:0]        tx_count, rx_count;
    logic [31:0]          rdata;
    logic                 error, loopback, rx_src, cts_ok, set_ovr, set_frm, set_par;
    logic [2:0]           status_clr;
    logic [7:0]           status;
    logic                 unused_bits;

`ifdef UART_LOOPBACK_EN
    localparam logic [6:0] CTRL_MASK = 7'h7F;
    assign loopback = ctrl_q[CTRL_LOOPBACK];
    assign rx_src   = loopback ? tx_q : rx;
`else
    localparam logic [6:0] CTRL_MASK = 7'h3F;
    assign loopback = 1'b0;
    assign rx_src   = rx;
`endif

    assign tx     = tx_q | loopback;
    assign rts    = rts_q;
    assign cts_ok = !ctrl_q[CTRL_FLOW_EN] || cts_s2_q || loopback;
    assign status = {(tx_state_q != IDLE), parity_q, framing_q, overrun_q,
                     tx_full, tx_empty, rx_full, rx_empty};
    assign bp.rdata         = rdata;
    assign bp.error         = error;
    assign bp.request_stall = 1'b0;
    assign unused_bits      = ^{bp.strobe, bp.addr[31:5], bp.wdata, tx_count};

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .nReset(nReset), .push(tx_push), .pop(tx_pop), .wdata(bp.wdata[DATA_BITS-1:0]),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count));

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .nReset(nReset), .push(rx_push), .pop(rx_pop), .wdata(rx_shift_q),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count));

    // Register decode: combinational read data/error, write side effects
    always_comb begin
        rdata      = '0;
        error      = 1'b0;
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        status_clr = 3'b000;
        if (bp.ren) begin
            case (bp.addr[4:0])
                ADDR_RXDATA: if (!rx_empty) begin
                    rdata  = {1'b1, {(31-DATA_BITS){1'b0}}, rx_rdata};
                    rx_pop = 1'b1;
                end
                ADDR_STATUS: rdata = {24'b0, status};
                ADDR_CTRL:   rdata = {25'b0, ctrl_q};
                ADDR_BAUD:   rdata = 32'(baud_q);
                default:     error = 1'b1;
            endcase
        end
        if (bp.wen) begin
            case (bp.addr[4:0])
                ADDR_TXDATA: if (tx_full) error = 1'b1; else tx_push = 1'b1;
                ADDR_STATUS: status_clr = bp.wdata[ST_PARITY_ERR:ST_OVERRUN];
                ADDR_CTRL:   ctrl_d = bp.wdata[6:0] & CTRL_MASK;
                ADDR_BAUD:   baud_d = (bp.wdata[DIV_WIDTH-1:0] < MIN_DIV) ? MIN_DIV : bp.wdata[DIV_WIDTH-1:0];
                default:     error = 1'b1;
            endcase
        end
    end

    // Sticky flags: a new error event wins over a same-cycle clear
    always_comb begin
        overrun_d = set_ovr | (overrun_q & ~status_clr[0]);
        framing_d = set_frm | (framing_q & ~status_clr[1]);
        parity_d  = set_par | (parity_q  & ~status_clr[2]);
        rts_d     = !ctrl_q[CTRL_FLOW_EN] || (rx_count <= CW'(FIFO_DEPTH - 2));
    end

    // TX FSM next state; the counter reloads from BAUD at every bit boundary
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - ONE;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = tx_cnt_q;
                if (ctrl_q[CTRL_TX_EN] && !tx_empty && cts_ok) begin
                    tx_state_d = START;
                    tx_cnt_d   = baud_q - ONE;
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_rdata;
                    tx_par_d   = ^tx_rdata;
                end
            end
            START: if (tx_cnt_q == '0) begin
                tx_state_d = DATA;
                tx_cnt_d   = baud_q - ONE;
                tx_bit_d   = '0;
            end
            DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = baud_q - ONE;
                if (tx_bit_q == LAST_BIT) begin
                    tx_bit_d   = '0;
                    tx_par_d   = tx_par_q ^ ctrl_q[CTRL_PAR_ODD];
                    tx_state_d = ctrl_q[CTRL_PAR_EN] ? PARITY : STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
            PARITY: if (tx_cnt_q == '0) begin
                tx_state_d = STOP;
                tx_cnt_d   = baud_q - ONE;
                tx_bit_d   = '0;
            end
            STOP: if (tx_cnt_q == '0) begin
                tx_cnt_d = baud_q - ONE;
                if (ctrl_q[CTRL_TWO_STOP] && tx_bit_q == '0) tx_bit_d   = 4'd1;
                else                                         tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
        case (tx_state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_shift_d[0];
            PARITY:  tx_d = tx_par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // RX FSM next state: half-bit start check, then mid-bit sampling
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - ONE;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        set_ovr    = 1'b0;
        set_frm    = 1'b0;
        set_par    = 1'b0;
        if (!ctrl_q[CTRL_RX_EN]) begin
            rx_state_d = IDLE;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    rx_cnt_d = rx_cnt_q;
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_d = START;
                        rx_cnt_d   = (baud_q >> 1) - ONE;
                        rx_perr_d  = 1'b0;
                    end
                end
                START: if (rx_cnt_q == '0) begin
                    rx_state_d = rx_s2_q ? IDLE : DATA;
                    rx_cnt_d   = baud_q - ONE;
                    rx_bit_d   = '0;
                end
                DATA: if (rx_cnt_q == '0) begin
                    rx_cnt_d   = baud_q - ONE;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == LAST_BIT) rx_state_d = ctrl_q[CTRL_PAR_EN] ? PARITY : STOP;
                end
                PARITY: if (rx_cnt_q == '0) begin
                    rx_perr_d  = (^rx_shift_q) ^ ctrl_q[CTRL_PAR_ODD] ^ rx_s2_q;
                    rx_state_d = STOP;
                    rx_cnt_d   = baud_q - ONE;
                end
                STOP: if (rx_cnt_q == '0) begin
                    rx_state_d = IDLE;
                    if (!rx_s2_q)               set_frm = 1'b1;
                    else if (rx_perr_q)         set_par = 1'b1;
                    else if (rx_full && !rx_pop) set_ovr = 1'b1;
                    else                        rx_push = 1'b1;
                end
                default: rx_state_d = IDLE;
            endcase
        end
    end

    // State registers, synchronisers and configuration; reset aborts any frame
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ctrl_q     <= '0;
            baud_q     <= DEFAULT_DIV;
            overrun_q  <= 1'b0;
            framing_q  <= 1'b0;
            parity_q   <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            cts_s1_q   <= 1'b0;
            cts_s2_q   <= 1'b0;
            rts_q      <= 1'b0;
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            overrun_q  <= overrun_d;
            framing_q  <= framing_d;
            parity_q   <= parity_d;
            rx_s1_q    <= rx_src;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            cts_s1_q   <= cts;
            cts_s2_q   <= cts_s1_q;
            rts_q      <= rts_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end
endmodule

// File: tb/tb_ahb_uart_v2.sv
// tb_ahb_uart_v2: register-access vector table plus directed serial
// sequences for ahb_uart_v2 (default parameters, divisor 4 for frames).
module tb_ahb_uart_v2;
    import uart_pkg::*;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

`ifdef UART_LOOPBACK_EN
    localparam logic [31:0] CTRL_ALL = 32'h7F;
`else
    localparam logic [31:0] CTRL_ALL = 32'h3F;
`endif

    logic clk, nReset, rx, tx, cts, rts;
    int   total, bad;
    logic [31:0] rd;
    logic        er;
    vec_t vecs[17];

    bus_protocol_if bp();

    ahb_uart_v2 dut (
        .clk(clk), .nReset(nReset), .rx(rx), .tx(tx), .cts(cts), .rts(rts), .bp(bp)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scores one comparison
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        bp.wen = 1'b1; bp.addr = {27'b0, a}; bp.wdata = d;
        #1 e = bp.error;
        @(posedge clk);
        #1 bp.wen = 1'b0;
    endtask

    task automatic busRead(input logic [4:0] a, output logic [31:0] r, output logic e);
        @(negedge clk);
        bp.ren = 1'b1; bp.addr = {27'b0, a};
        #1 begin r = bp.rdata; e = bp.error; end
        @(posedge clk);
        #1 bp.ren = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] r, output logic e);
        r = '0;
        if (v.wr) busWrite(v.addr, v.wdata, e);
        else      busRead(v.addr, r, e);
    endtask

    // One serial bit of four clocks on the rx pin
    task automatic driveBit(input logic b);
        #1 rx = b;
        repeat (4) @(posedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit withPar, input logic parBit, input logic stopBit);
        @(posedge clk);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
        if (withPar) driveBit(parBit);
        driveBit(stopBit);
        #1 rx = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    task automatic expectRead(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        busRead(a, r, e);
        checkOutput(name, r, exp);
    endtask

    task automatic quietWrite(input logic [4:0] a, input logic [31:0] d);
        logic e;
        busWrite(a, d, e);
    endtask

    initial begin
        logic [3:0] smp;
        logic [9:0] frame;
        int         lows;
        bit         found;

        total = 0; bad = 0;
        nReset = 1'b0; rx = 1'b1; cts = 1'b0;
        bp.wen = 1'b0; bp.ren = 1'b0; bp.addr = '0; bp.wdata = '0; bp.strobe = 4'hF;

        vecs[0]  = '{1'b0, ADDR_STATUS, 32'h0,        32'h05,  1'b0};
        vecs[1]  = '{1'b0, ADDR_CTRL,   32'h0,        32'h00,  1'b0};
        vecs[2]  = '{1'b0, ADDR_BAUD,   32'h0,        32'h364, 1'b0};
        vecs[3]  = '{1'b1, ADDR_BAUD,   32'h2,        32'h0,   1'b0};
        vecs[4]  = '{1'b0, ADDR_BAUD,   32'h0,        32'h4,   1'b0};
        vecs[5]  = '{1'b1, ADDR_BAUD,   32'hA,        32'h0,   1'b0};
        vecs[6]  = '{1'b0, ADDR_BAUD,   32'h0,        32'hA,   1'b0};
        vecs[7]  = '{1'b1, ADDR_CTRL,   32'hFF,       32'h0,   1'b0};
        vecs[8]  = '{1'b0, ADDR_CTRL,   32'h0,        CTRL_ALL, 1'b0};
        vecs[9]  = '{1'b1, ADDR_CTRL,   32'h0,        32'h0,   1'b0};
        vecs[10] = '{1'b0, ADDR_CTRL,   32'h0,        32'h0,   1'b0};
        vecs[11] = '{1'b0, 5'h14,       32'h0,        32'h0,   1'b1};
        vecs[12] = '{1'b1, 5'h18,       32'h1,        32'h0,   1'b1};
        vecs[13] = '{1'b0, ADDR_TXDATA, 32'h0,        32'h0,   1'b1};
        vecs[14] = '{1'b1, ADDR_RXDATA, 32'h12,       32'h0,   1'b1};
        vecs[15] = '{1'b0, ADDR_RXDATA, 32'h0,        32'h0,   1'b0};
        vecs[16] = '{1'b1, ADDR_BAUD,   32'h0001_0003, 32'h0,  1'b0};

        // Reset state
        #12;
        checkOutput("reset_tx", {31'b0, tx}, 32'd1);
        checkOutput("reset_rts", {31'b0, rts}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) nReset = 1'b1;
        @(negedge clk);
        checkOutput("rts_after_reset", {31'b0, rts}, 32'd1);

        // Register access table
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i], rd, er);
            if (!vecs[i].wr) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].expErr});
        end
        expectRead("baud_clamped_upper", ADDR_BAUD, 32'h4);

        // TX frame 0x55, 4 clocks per bit
        quietWrite(ADDR_CTRL, 32'h03);
        quietWrite(ADDR_TXDATA, 32'h55);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1'b1;
        end
        checkOutput("tx_start_seen", {31'b0, found}, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < 4; s++) begin
                if (!(b == 0 && s == 0)) @(negedge clk);
                smp[s] = tx;
            end
            checkOutput($sformatf("tx_bit%0d", b), {28'b0, smp}, {28'b0, {4{frame[b]}}});
        end
        expectRead("status_after_tx", ADDR_STATUS, 32'h05);

        // RX with even parity, good then bad parity, then a framing error
        quietWrite(ADDR_CTRL, 32'h06);
        sendFrame(8'hA5, 1'b1, 1'b0, 1'b1);
        expectRead("rx_a5", ADDR_RXDATA, 32'h8000_00A5);
        expectRead("rx_empty_after", ADDR_RXDATA, 32'h0);
        sendFrame(8'hA5, 1'b1, 1'b1, 1'b1);
        expectRead("parity_err_status", ADDR_STATUS, 32'h45);
        expectRead("parity_no_push", ADDR_RXDATA, 32'h0);
        quietWrite(ADDR_STATUS, 32'h40);
        expectRead("parity_cleared", ADDR_STATUS, 32'h05);
        quietWrite(ADDR_CTRL, 32'h02);
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b0);
        expectRead("framing_status", ADDR_STATUS, 32'h25);
        expectRead("framing_no_push", ADDR_RXDATA, 32'h0);
        quietWrite(ADDR_STATUS, 32'h20);
        expectRead("framing_cleared", ADDR_STATUS, 32'h05);

        // RX fill with flow control, rts drop and overrun
        quietWrite(ADDR_CTRL, 32'h22);
        for (int i = 0; i < 6; i++) sendFrame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        checkOutput("rts_free2", {31'b0, rts}, 32'd1);
        sendFrame(8'h16, 1'b0, 1'b0, 1'b1);
        checkOutput("rts_free1", {31'b0, rts}, 32'd0);
        sendFrame(8'h17, 1'b0, 1'b0, 1'b1);
        expectRead("rx_full_status", ADDR_STATUS, 32'h06);
        sendFrame(8'hFF, 1'b0, 1'b0, 1'b1);
        expectRead("overrun_status", ADDR_STATUS, 32'h16);
        quietWrite(ADDR_STATUS, 32'h10);
        expectRead("overrun_cleared", ADDR_STATUS, 32'h06);
        for (int i = 0; i < 8; i++)
            expectRead($sformatf("rx_fifo%0d", i), ADDR_RXDATA, 32'h8000_0010 + 32'(i));
        expectRead("rx_drained", ADDR_RXDATA, 32'h0);
        @(negedge clk);
        checkOutput("rts_recovered", {31'b0, rts}, 32'd1);

        // TX FIFO overflow with transmitter disabled
        quietWrite(ADDR_CTRL, 32'h00);
        for (int i = 0; i < 9; i++) begin
            busWrite(ADDR_TXDATA, 32'(i), er);
            checkOutput($sformatf("tx_push%0d_err", i), {31'b0, er}, (i == 8) ? 32'd1 : 32'd0);
        end
        expectRead("tx_full_status", ADDR_STATUS, 32'h09);

        // CTS blocks the transmitter, then releases it within 3 clocks
        quietWrite(ADDR_CTRL, 32'h21);
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        checkOutput("cts_blocked_lows", 32'(lows), 32'd0);
        cts = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 3 && !found; k++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1'b1;
        end
        checkOutput("cts_start_within3", {31'b0, found}, 32'd1);

        // Reset mid-DATA of byte 0x00
        repeat (8) @(negedge clk);
        checkOutput("pre_reset_tx_low", {31'b0, tx}, 32'd0);
        #2 nReset = 1'b0;
        #1;
        checkOutput("midframe_reset_tx", {31'b0, tx}, 32'd1);
        checkOutput("midframe_reset_rts", {31'b0, rts}, 32'd0);
        expectRead("reset_status", ADDR_STATUS, 32'h05);
        expectRead("reset_ctrl", ADDR_CTRL, 32'h0);
        expectRead("reset_baud", ADDR_BAUD, 32'h364);
        @(negedge clk) nReset = 1'b1;
        @(negedge clk);
        checkOutput("rts_after_rerelease", {31'b0, rts}, 32'd1);

`ifdef UART_LOOPBACK_EN
        // Internal loopback: pin stays high, byte arrives in RX FIFO
        quietWrite(ADDR_BAUD, 32'h4);
        quietWrite(ADDR_CTRL, 32'h43);
        quietWrite(ADDR_TXDATA, 32'h3C);
        lows = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        checkOutput("loopback_pin_lows", 32'(lows), 32'd0);
        expectRead("loopback_rx", ADDR_RXDATA, 32'h8000_003C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
